// File: rtl/four_bit_divider_pkg.sv
// rtl/four_bit_divider_pkg.sv - shared FSM encoding and sizing constants for the restoring divider
package four_bit_divider_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIN  = 2'd2
    } state_e;

    // Iteration counter must hold 0..width, so size it for width+1 values.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

    localparam int DEFAULT_CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/four_bit_divider_borrow_sub.sv
// rtl/four_bit_divider_borrow_sub.sv - N-bit ripple-borrow subtractor built from full-subtractor cells
module borrow_sub #(
    parameter int N = 5
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         bout
);

    logic [N:0] borrow;

    assign borrow[0] = 1'b0;

    for (genvar i = 0; i < N; i++) begin : g_cell
        assign diff[i]     = a[i] ^ b[i] ^ borrow[i];
        assign borrow[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & borrow[i]);
    end

    assign bout = borrow[N];

endmodule

// File: rtl/four_bit_divider.sv
// rtl/four_bit_divider.sv - sequential restoring divider; DIVIDER_EARLY_EXIT_EN skips iterations when A < B
module four_bit_divider
    import four_bit_divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             DIV_ZERO
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             div_zero_q, div_zero_d;

    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   trial;
    logic             trial_borrow;
    logic [WIDTH:0]   rem_step;
    logic [WIDTH-1:0] quo_step;

    // The remainder never reaches B, so its top bit is zero between iterations.
    logic unused_rem_msb;
    assign unused_rem_msb = rem_q[WIDTH];

    assign rem_sh = {rem_q[WIDTH-1:0], dvd_q[WIDTH-1]};

    borrow_sub #(
        .N(WIDTH + 1)
    ) u_borrow_sub (
        .a   (rem_sh),
        .b   ({1'b0, dsr_q}),
        .diff(trial),
        .bout(trial_borrow)
    );

    assign rem_step = trial_borrow ? rem_sh : trial;
    assign quo_step = {quo_q[WIDTH-2:0], ~trial_borrow};

    always_comb begin
        state_d    = state_q;
        dvd_d      = dvd_q;
        dsr_d      = dsr_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        cnt_d      = cnt_q;
        q_d        = q_q;
        r_d        = r_q;
        div_zero_d = div_zero_q;

        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    dvd_d      = A;
                    dsr_d      = B;
                    rem_d      = '0;
                    quo_d      = '0;
                    cnt_d      = '0;
                    div_zero_d = 1'b0;
                    if (B == '0) begin
                        q_d        = '1;
                        r_d        = A;
                        div_zero_d = 1'b1;
                        state_d    = ST_FIN;
                    end
`ifdef DIVIDER_EARLY_EXIT_EN
                    else if (A < B) begin
                        q_d     = '0;
                        r_d     = A;
                        state_d = ST_FIN;
                    end
`endif
                    else begin
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                rem_d = rem_step;
                quo_d = quo_step;
                dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_ITER) begin
                    q_d     = quo_step;
                    r_d     = rem_step[WIDTH-1:0];
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            dvd_q      <= '0;
            dsr_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            cnt_q      <= '0;
            q_q        <= '0;
            r_q        <= '0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            dvd_q      <= dvd_d;
            dsr_q      <= dsr_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            cnt_q      <= cnt_d;
            q_q        <= q_d;
            r_q        <= r_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign BUSY     = (state_q != ST_IDLE);
    assign DONE     = (state_q == ST_FIN);
    assign Q        = q_q;
    assign R        = r_q;
    assign DIV_ZERO = div_zero_q;

endmodule
